alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
- Execution-stage ALU that consumes the 4-bit Operation code produced by the ALU controller, together with two operands.
- Logic, add/sub and compare ops complete in one cycle.
- Shifts are iterative, one bit position per cycle, to keep the barrel shifter out of the datapath.
- Valid/ready handshakes on both input and output let the pipeline stall around multi-cycle shifts.

Parameters:
- WIDTH, 32, operand/result width in bits; power of two, >= 8.
- SHW, $clog2(WIDTH), derived; shift-amount width. Shift amount is B[SHW-1:0].

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operands and Operation are valid this cycle
- in_ready  out  1  block can accept a new operation
- Operation  in  4  op select (encoding below)
- A  in  WIDTH  operand A (rs1)
- B  in  WIDTH  operand B (rs2 or immediate); low SHW bits are the shift amount for shifts
- out_valid  out  1  result is valid
- out_ready  in  1  consumer takes the result
- result  out  WIDTH  ALU result
- zero  out  1  result == 0
- illegal  out  1  Operation was an undefined code

Behaviour:
- Operation encoding:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR
  - 0100 SLL; 0101 SRL; 0110 SUB; 0111 SRA
  - 1000 BEQ: computes A-B, zero flags equality
  - 1100 SLT: signed compare, result = {0..., $signed(A)<$signed(B)}
  - All other codes: result 0, illegal=1
- Arithmetic is modulo 2^WIDTH. No overflow/carry outputs.
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- Reset values: result=0, zero=0, illegal=0, out_valid=0. Internal shift counter and accumulator = 0.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid, capture A, B and Operation.
  - Shift op with shamt!=0: load accumulator with A, counter with shamt, go to SHIFT.
  - Otherwise: compute result in the same cycle, register it, go to DONE.
  - A shift with shamt=0 returns A in one cycle.
- SHIFT:
  - in_ready=0.
  - Each cycle, shift the accumulator by 1 and decrement the counter. SLL fills 0. SRL fills 0. SRA fills A[WIDTH-1].
  - When the counter goes from 1 to 0, register the result and go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - result/zero/illegal are held stable while out_ready=0.
  - On out_ready, go to IDLE. out_valid drops the next cycle.
  - There is no accept in the same cycle as drain; throughput is at most one op per 2 cycles.
- Latency: accept edge at cycle N gives out_valid in cycle N+1 for non-shift or shamt=0, and N+1+shamt for shifts. Maximum is N+WIDTH for shamt=WIDTH-1.
- zero is computed from the final registered result for every op, including shifts and SLT.
- in_valid while in_ready=0 is ignored. Inputs need not be held after the accept edge.
- reset mid-SHIFT or in DONE discards the operation, forces IDLE and clears all outputs the next cycle.
- Counter width SHW. The shift amount never exceeds WIDTH-1, so there is no wrap.

Test Plan:
- ADD A=0x7FFFFFFF, B=1, out_ready=1 -> out_valid one cycle after accept, result=0x80000000, zero=0. Then SUB 5-5 -> result=0, zero=1.
- SRA A=0x80000000, B=31 -> in_ready low for 31 cycles, out_valid at N+32, result=0xFFFFFFFF. SRL with same operands -> result=0x00000001.
- SLL A=0x1, B=0x25 (shamt=5) -> result=0x20 after 6 cycles. SLL with shamt=0 -> result=A after 1 cycle.
- SLT A=0xFFFFFFFF (-1), B=1 -> result=1. Swapped operands -> result=0. BEQ A=B=0x1234 -> zero=1.
- Backpressure: out_ready=0 for 5 cycles in DONE -> result/out_valid held stable, in_valid pulses ignored (in_ready=0). Accept occurs only after drain.
- Illegal code 1111 -> result=0, illegal=1, zero=1. Reset asserted mid-SHIFT (SLL shamt=20, reset at cycle 7) -> IDLE next cycle, out_valid=0, result=0, next ADD completes normally.

Source files
------------

// File: rtl/alu_multicycle_if.sv
// Operand/result handshake bundle for the multicycle ALU: valid/ready on the request and response sides.
// The slave modport is the ALU's view; the master modport is the issuing/consuming pipeline's view.
interface alu_multicycle_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       Operation;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    modport slave (
        input  in_valid,
        output in_ready,
        input  Operation,
        input  A,
        input  B,
        output out_valid,
        input  out_ready,
        output result,
        output zero,
        output illegal
    );

    modport master (
        output in_valid,
        input  in_ready,
        output Operation,
        output A,
        output B,
        input  out_valid,
        output out_ready,
        input  result,
        input  zero,
        input  illegal
    );
endinterface

// File: rtl/alu_multicycle.sv
// Execution ALU: logic/add/sub/compare in 1 cycle, shifts iterate 1 bit/cycle (1+shamt cycles).
// Accepts only in IDLE; result is held in DONE until out_ready, so at most one op per 2 cycles.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    alu_multicycle_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_BEQ = 4'b1000;
    localparam logic [3:0] OP_SLT = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_acc;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_illegal;

    logic [SHW-1:0]   w_shamt;
    logic             w_is_shift;
    logic             w_accept;
    logic             w_start_shift;
    logic             w_shift_last;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_illegal;
    logic [WIDTH-1:0] w_acc_step;

    assign w_shamt       = bus.B[SHW-1:0];
    assign w_is_shift    = (bus.Operation == OP_SLL) || (bus.Operation == OP_SRL) ||
                           (bus.Operation == OP_SRA);
    assign w_accept      = bus.in_valid && (r_state == S_IDLE);
    assign w_start_shift = w_accept && w_is_shift && (w_shamt != '0);
    assign w_shift_last  = (r_state == S_SHIFT) && (r_cnt == SHW'(1));
    assign w_diff        = bus.A - bus.B;

    // Single-cycle result; a shift only lands here when its amount is zero, so it passes A through.
    always_comb begin
        w_alu_result  = '0;
        w_alu_illegal = 1'b0;
        case (bus.Operation)
            OP_AND:                 w_alu_result = bus.A & bus.B;
            OP_OR:                  w_alu_result = bus.A | bus.B;
            OP_ADD:                 w_alu_result = bus.A + bus.B;
            OP_XOR:                 w_alu_result = bus.A ^ bus.B;
            OP_SLL, OP_SRL, OP_SRA: w_alu_result = bus.A;
            OP_SUB, OP_BEQ:         w_alu_result = w_diff;
            OP_SLT:                 w_alu_result = {{(WIDTH-1){1'b0}},
                                                    ($signed(bus.A) < $signed(bus.B))};
            default:                w_alu_illegal = 1'b1;
        endcase
    end

    // One-bit step of the iterative shifter; SRA replicates the sign bit, which never changes.
    always_comb begin
        w_acc_step = r_acc;
        case (r_op)
            OP_SLL:  w_acc_step = {r_acc[WIDTH-2:0], 1'b0};
            OP_SRL:  w_acc_step = {1'b0, r_acc[WIDTH-1:1]};
            default: w_acc_step = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_start_shift ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (w_shift_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            S_IDLE:  bus.in_ready  = 1'b1;
            S_DONE:  bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op      <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_op <= bus.Operation;
            if (w_start_shift) begin
                r_acc <= bus.A;
                r_cnt <= w_shamt;
            end else begin
                r_result  <= w_alu_result;
                r_zero    <= (w_alu_result == '0);
                r_illegal <= w_alu_illegal;
            end
        end else if (r_state == S_SHIFT) begin
            r_acc <= w_acc_step;
            r_cnt <= r_cnt - SHW'(1);
            if (w_shift_last) begin
                r_result  <= w_acc_step;
                r_zero    <= (w_acc_step == '0);
                r_illegal <= 1'b0;
            end
        end
    end

    assign bus.result  = r_result;
    assign bus.zero    = r_zero;
    assign bus.illegal = r_illegal;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: hand-computed vectors for every op class, latency, backpressure and reset.
module tb_alu_multicycle;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    alu_multicycle_if #(.WIDTH(32)) bus ();

    alu_multicycle #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single accept edge, then scramble the inputs.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid  = 1'b1;
        bus.Operation = op;
        bus.A         = a;
        bus.B         = b;
        step();
        bus.in_valid  = 1'b0;
        bus.Operation = 4'($urandom);
        bus.A         = $urandom;
        bus.B         = $urandom;
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                          input logic exp_zero, input logic exp_ill);
        int lat;
        int rdy_seen;
        chk({tag, ".in_ready_pre"}, 32'(bus.in_ready), 32'd1);
        issue(op, a, b);
        lat      = 0;
        rdy_seen = 0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) rdy_seen++;
            step();
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".in_ready_busy"}, 32'(rdy_seen + int'(bus.in_ready)), 32'd0);
        chk({tag, ".result"}, bus.result, exp_res);
        chk({tag, ".zero"}, 32'(bus.zero), 32'(exp_zero));
        chk({tag, ".illegal"}, 32'(bus.illegal), 32'(exp_ill));
        step();
        chk({tag, ".drained"}, {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.Operation = 4'h0;
        bus.A         = '0;
        bus.B         = '0;
        step();
        step();
        reset = 1'b0;
        chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset.result", bus.result, 32'd0);
        chk("reset.zero", 32'(bus.zero), 32'd0);
        chk("reset.illegal", 32'(bus.illegal), 32'd0);

        run_op("add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 0,  32'h8000_0000, 1'b0, 1'b0);
        run_op("sub_eq",   4'b0110, 32'd5,         32'd5,         0,  32'h0000_0000, 1'b1, 1'b0);
        run_op("sra31",    4'b0111, 32'h8000_0000, 32'd31,        31, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("srl31",    4'b0101, 32'h8000_0000, 32'd31,        31, 32'h0000_0001, 1'b0, 1'b0);
        run_op("sll5",     4'b0100, 32'h0000_0001, 32'h0000_0025, 5,  32'h0000_0020, 1'b0, 1'b0);
        run_op("sll0",     4'b0100, 32'hDEAD_BEEF, 32'h0000_0020, 0,  32'hDEAD_BEEF, 1'b0, 1'b0);
        run_op("sra_pos",  4'b0111, 32'h4000_0000, 32'd3,         3,  32'h0800_0000, 1'b0, 1'b0);
        run_op("srl_out",  4'b0101, 32'h0000_0003, 32'd2,         2,  32'h0000_0000, 1'b1, 1'b0);
        run_op("slt_neg",  4'b1100, 32'hFFFF_FFFF, 32'h0000_0001, 0,  32'h0000_0001, 1'b0, 1'b0);
        run_op("slt_swap", 4'b1100, 32'h0000_0001, 32'hFFFF_FFFF, 0,  32'h0000_0000, 1'b1, 1'b0);
        run_op("beq",      4'b1000, 32'h0000_1234, 32'h0000_1234, 0,  32'h0000_0000, 1'b1, 1'b0);
        run_op("and",      4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0,  32'h00F0_00F0, 1'b0, 1'b0);
        run_op("or",       4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0,  32'hFFF0_FFF0, 1'b0, 1'b0);
        run_op("xor",      4'b0011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0,  32'hFF00_FF00, 1'b0, 1'b0);
        run_op("ill_f",    4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 0,  32'h0000_0000, 1'b1, 1'b1);
        run_op("ill_9",    4'b1001, 32'h0000_0001, 32'h0000_0002, 0,  32'h0000_0000, 1'b1, 1'b1);

        // Result must hold in DONE while the consumer stalls; new requests are refused.
        bus.out_ready = 1'b0;
        issue(4'b0010, 32'd3, 32'd4);
        chk("bp.out_valid0", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid  = 1'b1;
            bus.Operation = 4'b0011;
            bus.A         = 32'hAAAA_0000 + 32'(i);
            bus.B         = 32'h5555_0000;
            step();
            chk("bp.out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp.in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp.result", bus.result, 32'd7);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("bp.drained", {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
        run_op("bp.next", 4'b0010, 32'd10, 32'd20, 0, 32'd30, 1'b0, 1'b0);

        // Reset in the middle of a long shift abandons it.
        issue(4'b0100, 32'h0000_0001, 32'd20);
        for (int i = 0; i < 6; i++) step();
        chk("rst.mid_in_ready", 32'(bus.in_ready), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst.result", bus.result, 32'd0);
        chk("rst.zero", 32'(bus.zero), 32'd0);
        chk("rst.illegal", 32'(bus.illegal), 32'd0);
        for (int i = 0; i < 20; i++) step();
        chk("rst.stays_idle", {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
        run_op("rst.add", 4'b0010, 32'd2, 32'd3, 0, 32'd5, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
